// File: rtl/con_ff_pkg.sv
// con_ff_pkg: shared condition codes and FSM state encoding for the branch-condition unit.
package con_ff_pkg;

    localparam int unsigned COND_W = 3;

    // Condition-field encodings (ir[COND_LSB+2:COND_LSB])
    localparam logic [COND_W-1:0] COND_ZERO    = 3'b000;  // z
    localparam logic [COND_W-1:0] COND_NONZERO = 3'b001;  // ~z
    localparam logic [COND_W-1:0] COND_PLUS    = 3'b010;  // ~n (positive or zero)
    localparam logic [COND_W-1:0] COND_MINUS   = 3'b011;  // n
    localparam logic [COND_W-1:0] COND_GREATER = 3'b100;  // ~n & ~z
    localparam logic [COND_W-1:0] COND_LESSEQ  = 3'b101;  // n | z
    localparam logic [COND_W-1:0] COND_ALWAYS  = 3'b110;
    localparam logic [COND_W-1:0] COND_NEVER   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCapt = 2'b01,
        StResv = 2'b10
    } state_e;

endpackage

// File: rtl/con_ff_eval.sv
// con_ff_eval: combinational evaluation of a 3-bit condition code against an operand.
// Shared with the ALU-flag path, so it carries no state.
module con_ff_eval
    import con_ff_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] op,
    input  logic [COND_W-1:0] cond,
    output logic              result
);

    logic z;
    logic n;

    assign z = ~|op;
    assign n = op[DATA_W-1];

    // Decode the condition code into the taken/not-taken result.
    always_comb begin
        result = 1'b0;
        unique case (cond)
            COND_ZERO:    result = z;
            COND_NONZERO: result = ~z;
            COND_PLUS:    result = ~n;
            COND_MINUS:   result = n;
            COND_GREATER: result = ~n & ~z;
            COND_LESSEQ:  result = n | z;
            COND_ALWAYS:  result = 1'b1;
            COND_NEVER:   result = 1'b0;
        endcase
    end

endmodule

// File: rtl/con_ff_unit.sv
// con_ff_unit: clocked branch-condition unit. Captures the bus operand and IR condition field
// on a rising con_in edge, evaluates over two cycles and presents a held result with a
// one-cycle valid pulse, plus overrun detection, flush and saturating statistics.
module con_ff_unit
    import con_ff_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IR_W     = 32,
    parameter int unsigned COND_LSB = 19,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              con_in,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [IR_W-1:0]   ir,
    input  logic              flush,
    output logic              con_out,
    output logic              con_valid,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  eval_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic              con_in_q;
    logic [DATA_W-1:0] op_q;
    logic [COND_W-1:0] cond_q;
    logic              res_q;

    logic              start;
    logic              eval_res;
    logic [COND_W-1:0] ir_cond;
    logic              unused_ir;

    assign start     = con_in & ~con_in_q;
    assign ir_cond   = ir[COND_LSB +: COND_W];
    // Only the condition field of ir is consumed; the rest is ignored here.
    assign unused_ir = ^ir;
    assign busy      = (state_q != StIdle);

    con_ff_eval #(
        .DATA_W (DATA_W)
    ) u_eval (
        .op     (op_q),
        .cond   (cond_q),
        .result (eval_res)
    );

    // Edge detect, FSM, operand capture, result/handshake registers and saturating counters.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            con_in_q  <= 1'b0;
            op_q      <= '0;
            cond_q    <= '0;
            res_q     <= 1'b0;
            con_out   <= 1'b0;
            con_valid <= 1'b0;
            overrun   <= 1'b0;
            taken_cnt <= '0;
            eval_cnt  <= '0;
        end else begin
            // Edge register tracks con_in every cycle so a held-high level never re-arms.
            con_in_q  <= con_in;
            con_valid <= 1'b0;

            // A request while busy is dropped but remembered, even if flush also arrives.
            if (start && busy) begin
                overrun <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        op_q    <= bus_in;
                        cond_q  <= ir_cond;
                        state_q <= StCapt;
                    end
                end
                StCapt: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        res_q   <= eval_res;
                        state_q <= StResv;
                    end
                end
                StResv: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        con_out   <= res_q;
                        con_valid <= 1'b1;
                        if (eval_cnt != CntMax) begin
                            eval_cnt <= eval_cnt + CntOne;
                        end
                        // taken_cnt can never pass eval_cnt since both stop at CntMax.
                        if (res_q && (taken_cnt != CntMax)) begin
                            taken_cnt <= taken_cnt + CntOne;
                        end
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
